// File: rtl/spi_master_arb.sv
// Purpose : two-client SPI master (mode 0, ss active-high, bit [0] first) with round-robin bus arbitration.
// Latency : grant 1 clk after req; 16*CLKDIV clks from tx_ready strobe to rx_valid strobe; SS_GAP clks of release.
// Backpressure: the granted client's byte waits in LOAD until tx_valid; ss stays high until req drops at a byte boundary.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   req[1:0]            per-client bus request, held for a whole burst
//   gnt[1:0]            registered one-hot grant (0 when the bus is free)
//   tx0_dat, tx1_dat    per-client byte to send, bit [0] goes out first
//   tx_valid[1:0]       per-client byte valid (ignored unless granted)
//   tx_ready[1:0]       1-cycle accept strobe towards the granted client
//   rx_dat, rx_valid    last received byte and its 1-cycle update strobe
//   busy                controller not idle
//   sclk, mosi, miso,ss SPI bus
module spi_master_arb #(
  parameter int CLKDIV = 2,
  parameter int SS_GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  input  logic [0:7] tx0_dat,
  input  logic [0:7] tx1_dat,
  input  logic [1:0] tx_valid,
  output logic [1:0] tx_ready,
  output logic [0:7] rx_dat,
  output logic       rx_valid,
  output logic       busy,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ss
);

  localparam int DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int GAP_W = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKDIV - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(SS_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             last_q, last_d;
  logic             ss_q, ss_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic [1:0]       tx_ready_q, tx_ready_d;
  logic             rx_valid_q, rx_valid_d;
  logic [0:7]       rx_dat_q, rx_dat_d;
  logic [0:7]       shreg_q, shreg_d;
  logic [0:7]       rxsh_q, rxsh_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       tog_q, tog_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  // Granted client index; only meaningful while gnt_q is non-zero.
  logic       sel;
  logic       cur_req;
  logic       cur_valid;
  logic [0:7] cur_dat;
  logic       winner;
  logic [2:0] bit_idx;
  logic [2:0] nxt_idx;

  assign sel       = gnt_q[1];
  assign cur_req   = req[sel];
  assign cur_valid = tx_valid[sel];
  assign cur_dat   = sel ? tx1_dat : tx0_dat;
  // Each bit spans two toggles: even toggle = rising edge, odd = falling.
  assign bit_idx   = tog_q[3:1];
  assign nxt_idx   = bit_idx + 3'd1;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    ss_d       = ss_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    tx_ready_d = 2'b00;
    rx_valid_d = 1'b0;
    rx_dat_d   = rx_dat_q;
    shreg_d    = shreg_q;
    rxsh_d     = rxsh_q;
    div_d      = div_q;
    tog_d      = tog_q;
    gap_d      = gap_q;
    winner     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          // On a tie the client that did not win last time gets the bus.
          winner  = (req == 2'b11) ? ~last_q : req[1];
          gnt_d   = winner ? 2'b10 : 2'b01;
          last_d  = winner;
          ss_d    = 1'b1;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (!cur_req) begin
          ss_d    = 1'b0;
          gnt_d   = 2'b00;
          sclk_d  = 1'b0;
          gap_d   = '0;
          state_d = S_RELEASE;
        end else if (cur_valid) begin
          tx_ready_d = sel ? 2'b10 : 2'b01;
          shreg_d    = cur_dat;
          mosi_d     = cur_dat[0];
          div_d      = '0;
          tog_d      = 4'd0;
          state_d    = S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (div_q == DIV_MAX) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          tog_d  = tog_q + 4'd1;
          if (!sclk_q) begin
            rxsh_d[bit_idx] = miso;
          end else if (bit_idx != 3'd7) begin
            mosi_d = shreg_q[nxt_idx];
          end
          // Last falling edge: bit 7 was sampled on the previous rising edge.
          if (tog_q == 4'd15) begin
            rx_dat_d   = rxsh_q;
            rx_valid_d = 1'b1;
            state_d    = S_LOAD;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_RELEASE: begin
        if (gap_q == GAP_MAX) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= 2'b00;
      last_q     <= 1'b1;
      ss_q       <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      tx_ready_q <= 2'b00;
      rx_valid_q <= 1'b0;
      rx_dat_q   <= '0;
      shreg_q    <= '0;
      rxsh_q     <= '0;
      div_q      <= '0;
      tog_q      <= 4'd0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      ss_q       <= ss_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      rx_dat_q   <= rx_dat_d;
      shreg_q    <= shreg_d;
      rxsh_q     <= rxsh_d;
      div_q      <= div_d;
      tog_q      <= tog_d;
      gap_q      <= gap_d;
    end
  end

  assign gnt      = gnt_q;
  assign ss       = ss_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign tx_ready = tx_ready_q;
  assign rx_valid = rx_valid_q;
  assign rx_dat   = rx_dat_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_spi_master_arb.sv
module tb_spi_master_arb;

  localparam int CLKDIV = 2;
  localparam int SS_GAP = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [0:7] tx0_dat, tx1_dat;
  logic [1:0] tx_valid;
  logic [1:0] tx_ready;
  logic [0:7] rx_dat;
  logic       rx_valid;
  logic       busy;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       ss;

  int errors = 0;
  int checks = 0;
  logic m_last;  // reference model: index of last grant winner

  spi_master_arb #(.CLKDIV(CLKDIV), .SS_GAP(SS_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
    .tx0_dat(tx0_dat), .tx1_dat(tx1_dat), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_dat(rx_dat), .rx_valid(rx_valid), .busy(busy),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss(ss)
  );

  always #5 clk = ~clk;

  // Slave model: presents sl_byte bit [0] first, advancing after each rising sclk.
  logic [0:7] sl_byte = 8'h00;
  logic [2:0] rbit = 3'd0;
  always @(posedge sclk) rbit = rbit + 3'd1;
  always @(posedge ss) rbit = 3'd0;
  assign miso = sl_byte[rbit];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // tx_ready must only ever go to the granted client.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && tx_ready !== 2'b00) chk("tx_ready_granted_only", {30'b0, tx_ready}, {30'b0, gnt});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst_n = 1'b0; req = 2'b00; tx_valid = 2'b00; tx0_dat = '0; tx1_dat = '0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    m_last = 1'b1;
  endtask

  // One byte on an already granted bus; the DUT is expected to sit in LOAD.
  task automatic xfer_byte(input logic [7:0] tx, input logic [7:0] sl, input logic [1:0] eg,
                           input int dly, input string nm, input bit drop_mid);
    int n, t, rises;
    bit hold_ok;
    logic [0:7] cap;
    logic prev;
    tx0_dat = tx; tx1_dat = tx; sl_byte = sl;
    if (dly > 0) begin
      repeat (dly) step();
      chk({nm, " wait_hold"}, {29'b0, tx_ready, sclk, ss}, 32'b001);
    end
    tx_valid = 2'b11;
    n = 0;
    do begin step(); n++; end while (tx_ready == 2'b00 && n < 50);
    chk({nm, " accept_lat"}, n, 1);
    chk({nm, " tx_ready"}, {30'b0, tx_ready}, {30'b0, eg});
    tx_valid = 2'b00;
    cap = '0; rises = 0; t = 0; hold_ok = 1'b1; prev = sclk;
    do begin
      step(); t++;
      if (sclk && !prev) begin
        if (rises < 8) cap[rises] = mosi;
        rises++;
        if (drop_mid && rises == 4) req = 2'b00;
      end
      if (ss !== 1'b1 || gnt !== eg) hold_ok = 1'b0;
      prev = sclk;
    end while (!rx_valid && t < 100);
    chk({nm, " byte_lat"}, t, 16 * CLKDIV);
    chk({nm, " rx_dat"}, {24'b0, rx_dat}, {24'b0, sl});
    chk({nm, " mosi_bits"}, {24'b0, cap}, {24'b0, tx});
    chk({nm, " rises"}, rises, 8);
    chk({nm, " ss_gnt_hold"}, {31'b0, hold_ok}, 1);
  endtask

  task automatic run_burst(input logic [1:0] rp, input int nb, input logic [23:0] txs,
                           input logic [23:0] sls, input logic [1:0] eg, input int dly,
                           input string nm, input bit drop_mid);
    int n, g;
    bit low_ok;
    req = rp;
    n = 0;
    do begin step(); n++; end while (gnt == 2'b00 && n < 10);
    chk({nm, " gnt"}, {30'b0, gnt}, {30'b0, eg});
    chk({nm, " ss_sclk_at_grant"}, {30'b0, ss, sclk}, 32'b10);
    for (int b = 0; b < nb; b++)
      xfer_byte(txs[23 - 8*b -: 8], sls[23 - 8*b -: 8], eg, dly, nm, drop_mid && (b == nb - 1));
    req = 2'b00;
    step();
    chk({nm, " release"}, {29'b0, ss, gnt}, 32'b0);
    g = 0; low_ok = 1'b1;
    while (busy && g < 50) begin
      g++;
      if (ss !== 1'b0 || sclk !== 1'b0) low_ok = 1'b0;
      step();
    end
    chk({nm, " gap_len"}, g, SS_GAP);
    chk({nm, " gap_lines_low"}, {31'b0, low_ok}, 1);
  endtask

  typedef struct {
    logic [1:0]  rp;
    int          nb;
    logic [23:0] txs;
    logic [23:0] sls;
    int          dly;
    logic [1:0]  exp_gnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [1:0] rp, eg, seq_gnt;
    logic w;
    int nb, n, lowcnt, togs;
    bit rxv_seen;
    logic prev;

    vecs[0] = '{2'b01, 1, 24'h6A0000, 24'h950000, 0, 2'b01};
    vecs[1] = '{2'b10, 3, 24'h6A91FF, 24'h3CA500, 0, 2'b10};
    vecs[2] = '{2'b11, 1, 24'h000000, 24'hFF0000, 0, 2'b01};
    vecs[3] = '{2'b11, 2, 24'h817E00, 24'h5AC300, 1, 2'b10};
    vecs[4] = '{2'b10, 1, 24'hA50000, 24'h110000, 20, 2'b10};
    vecs[5] = '{2'b11, 1, 24'hFF0000, 24'h000000, 0, 2'b01};

    do_reset();
    chk("reset_outputs", {18'b0, gnt, tx_ready, rx_dat, rx_valid, busy, sclk, mosi, ss}, 32'b0);

    for (int i = 0; i < 6; i++) begin
      run_burst(vecs[i].rp, vecs[i].nb, vecs[i].txs, vecs[i].sls, vecs[i].exp_gnt,
                vecs[i].dly, $sformatf("vec%0d", i), 1'b0);
      m_last = vecs[i].exp_gnt[1];
    end

    // req dropped during bit 3: byte completes, then release.
    run_burst(2'b01, 1, 24'hC30000, 24'h690000, m_last == 1'b1 ? 2'b01 : 2'b01, 0, "drop_mid", 1'b1);
    m_last = 1'b0;

    // Randomized bursts against the round-robin reference model.
    for (int i = 0; i < 8; i++) begin
      rp = 2'($urandom_range(1, 3));
      nb = $urandom_range(1, 3);
      w  = (rp == 2'b11) ? ~m_last : rp[1];
      m_last = w;
      eg = w ? 2'b10 : 2'b01;
      run_burst(rp, nb, 24'($urandom), 24'($urandom), eg, $urandom_range(0, 3),
                $sformatf("rnd%0d", i), 1'b0);
    end

    // Both clients requesting from reset, one byte each, round-robin order.
    do_reset();
    req = 2'b11; tx_valid = 2'b11; tx0_dat = 8'h5A; tx1_dat = 8'hA5;
    lowcnt = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (gnt == 2'b00 && n < 20) begin
        if (ss == 1'b0) lowcnt++;
        step(); n++;
      end
      chk($sformatf("rr_gnt%0d", i), {30'b0, gnt}, (i % 2 == 1) ? 32'd2 : 32'd1);
      if (i > 0) chk($sformatf("rr_gap%0d", i), {31'b0, lowcnt >= SS_GAP}, 1);
      seq_gnt = gnt;
      n = 0;
      while (!rx_valid && n < 100) begin step(); n++; end
      req = req & ~seq_gnt;
      lowcnt = 0;
      n = 0;
      while (gnt != 2'b00 && n < 10) begin step(); n++; end
      req = 2'b11;
    end
    req = 2'b00; tx_valid = 2'b00;
    n = 0;
    while (busy && n < 100) begin step(); n++; end

    // Reset mid-SHIFT after 5 sclk toggles.
    req = 2'b01; tx_valid = 2'b01; tx0_dat = 8'hF0;
    n = 0;
    while (tx_ready == 2'b00 && n < 20) begin step(); n++; end
    togs = 0; prev = sclk; n = 0;
    while (togs < 5 && n < 100) begin
      step(); n++;
      if (sclk != prev) togs++;
      prev = sclk;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_lines", {28'b0, ss, sclk, gnt}, 32'b0);
    rxv_seen = 1'b0;
    repeat (3) begin step(); if (rx_valid) rxv_seen = 1'b1; end
    chk("abort_no_rx_valid", {31'b0, rxv_seen}, 0);
    req = 2'b11; tx_valid = 2'b00;
    rst_n = 1'b1;
    step();
    chk("post_reset_gnt", {30'b0, gnt}, 32'd1);
    req = 2'b00;
    n = 0;
    while (busy && n < 100) begin step(); n++; end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
